// File: rtl/pad_pkg.sv
// Shared definitions for the pad input conditioner: button and direction
// indices, stick centre, auto-repeat state encoding and the per-axis
// deadzone/hysteresis helper.
package pad_pkg;

    localparam int NUM_BTN      = 12;
    localparam int NUM_DIR      = 4;
    localparam int STICK_CENTER = 128;

    localparam int BTN_A       = 0;
    localparam int BTN_B       = 1;
    localparam int BTN_X       = 2;
    localparam int BTN_Y       = 3;
    localparam int BTN_START   = 4;
    localparam int BTN_L       = 5;
    localparam int BTN_R       = 6;
    localparam int BTN_Z       = 7;
    localparam int BTN_D_UP    = 8;
    localparam int BTN_D_DOWN  = 9;
    localparam int BTN_D_RIGHT = 10;
    localparam int BTN_D_LEFT  = 11;

    localparam int DIR_UP    = 0;
    localparam int DIR_DOWN  = 1;
    localparam int DIR_RIGHT = 2;
    localparam int DIR_LEFT  = 3;

    typedef enum logic [1:0] {
        AR_IDLE   = 2'd0,
        AR_DELAY  = 2'd1,
        AR_REPEAT = 2'd2
    } ar_state_e;

    // One stick axis: flags[0] = positive direction, flags[1] = negative.
    // Enter at |d| >= deadzone, leave once |d| drops below deadzone - hyst.
    // Both flags can never be set together because deadzone > hyst.
    function automatic logic [1:0] axis_update(input logic [7:0] axis,
                                               input logic [1:0] flags,
                                               input int         deadzone,
                                               input int         hyst);
        int         d;
        logic [1:0] nxt;
        d   = int'(axis) - STICK_CENTER;
        nxt = flags;
        if (d >= deadzone)               nxt[0] = 1'b1;
        else if (d < deadzone - hyst)    nxt[0] = 1'b0;
        if (d <= -deadzone)              nxt[1] = 1'b1;
        else if (d > -(deadzone - hyst)) nxt[1] = 1'b0;
        return nxt;
    endfunction

endpackage

// File: rtl/pad_debounce.sv
// Single-bit debouncer: the level flips only after DEBOUNCE_N consecutive
// sample ticks that disagree with it. state_next exposes the value the
// register will take at the coming edge so the parent can build pulses that
// line up with the state change.
module pad_debounce #(
    parameter int DEBOUNCE_N = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    output logic state,
    output logic state_next
);

    localparam int CW = (DEBOUNCE_N > 1) ? $clog2(DEBOUNCE_N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_N - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    // Next-state: reset the run on agreement, flip after a full run.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_next = state;
        cnt_next   = cnt;
        if (tick) begin
            if (raw == state) begin
                cnt_next = '0;
            end else if (cnt == CNT_LAST) begin
                state_next = raw;
                cnt_next   = '0;
            end else begin
                cnt_next = cnt + 1'b1;
            end
        end
    end

    // State and run-length registers.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            state <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

endmodule

// File: rtl/pad_input_conditioner.sv
// GameCube pad input conditioner: sample-tick divider, per-button debounce
// with press/release pulses, stick-to-4-way conversion with deadzone and
// hysteresis, and a merged navigation bus with one-cycle nav pulses.
// Define PAD_AUTOREPEAT_EN to add menu-style auto-repeat on the nav bus;
// without it nav_pulse only fires on newly set directions.
module pad_input_conditioner
    import pad_pkg::*;
#(
    parameter int SAMPLE_DIV   = 100000,
    parameter int DEBOUNCE_N   = 3,
    parameter int DEADZONE     = 40,
    parameter int HYST         = 10,
    parameter int REPEAT_DELAY = 25,
    parameter int REPEAT_RATE  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_BTN-1:0]   btn_raw,
    input  logic [7:0]           joy_x,
    input  logic [7:0]           joy_y,
    output logic                 sample_tick,
    output logic [NUM_BTN-1:0]   btn_state,
    output logic [NUM_BTN-1:0]   btn_press,
    output logic [NUM_BTN-1:0]   btn_release,
    output logic [NUM_DIR-1:0]   stick_dir,
    output logic [NUM_DIR-1:0]   nav_dir,
    output logic [NUM_DIR-1:0]   nav_pulse
);

    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

    logic [DIV_W-1:0]   div_cnt;
    logic [NUM_BTN-1:0] btn_next;
    logic [1:0]         x_flags, y_flags;
    logic [1:0]         x_next, y_next;
    logic [NUM_DIR-1:0] stick_next;
    logic [NUM_DIR-1:0] nav_next;
    logic [NUM_DIR-1:0] pulse_next;

    // Free-running sample divider, 0..SAMPLE_DIV-1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 div_cnt <= '0;
        else if (div_cnt == DIV_LAST) div_cnt <= '0;
        else                        div_cnt <= div_cnt + 1'b1;
    end

    assign sample_tick = (div_cnt == DIV_LAST);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_deb
            pad_debounce #(.DEBOUNCE_N(DEBOUNCE_N)) u_deb (
                .clk       (clk),
                .reset     (reset),
                .tick      (sample_tick),
                .raw       (btn_raw[gi]),
                .state     (btn_state[gi]),
                .state_next(btn_next[gi])
            );
        end
    endgenerate

    // Button edge pulses, produced at the tick edge that changes btn_state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_press   <= '0;
            btn_release <= '0;
        end else begin
            btn_press   <= sample_tick ? (btn_next & ~btn_state) : '0;
            btn_release <= sample_tick ? (~btn_next & btn_state) : '0;
        end
    end

    assign x_next = axis_update(joy_x, x_flags, DEADZONE, HYST);
    assign y_next = axis_update(joy_y, y_flags, DEADZONE, HYST);

    // Stick direction flags, refreshed once per sample tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_flags <= '0;
            y_flags <= '0;
        end else if (sample_tick) begin
            x_flags <= x_next;
            y_flags <= y_next;
        end
    end

    assign stick_dir  = {x_flags[1], x_flags[0], y_flags[1], y_flags[0]};
    assign stick_next = {x_next[1],  x_next[0],  y_next[1],  y_next[0]};
    assign nav_dir    = stick_dir  | btn_state[BTN_D_LEFT:BTN_D_UP];
    assign nav_next   = stick_next | btn_next[BTN_D_LEFT:BTN_D_UP];

`ifdef PAD_AUTOREPEAT_EN
    localparam int RC_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RC_W   = $clog2(RC_MAX + 1);

    ar_state_e       ar_state, ar_state_next;
    logic [RC_W-1:0] rcnt, rcnt_next;

    // Auto-repeat state and down-counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ar_state <= AR_IDLE;
            rcnt     <= '0;
        end else begin
            ar_state <= ar_state_next;
            rcnt     <= rcnt_next;
        end
    end

    // Auto-repeat decisions on the post-tick nav value.
    always_comb begin
        ar_state_next = ar_state;
        rcnt_next     = rcnt;
        pulse_next    = '0;
        if (sample_tick) begin
            if (nav_next == '0) begin
                ar_state_next = AR_IDLE;
                rcnt_next     = '0;
            end else if (nav_next != nav_dir) begin
                pulse_next    = nav_next & ~nav_dir;
                rcnt_next     = RC_W'(REPEAT_DELAY);
                ar_state_next = AR_DELAY;
            end else if (rcnt == RC_W'(1)) begin
                pulse_next    = nav_next;
                rcnt_next     = RC_W'(REPEAT_RATE);
                ar_state_next = AR_REPEAT;
            end else begin
                rcnt_next = rcnt - 1'b1;
            end
        end
    end
`else
    // Edge-only navigation: pulse newly set directions at the tick edge.
    always_comb begin
        pulse_next = sample_tick ? (nav_next & ~nav_dir) : '0;
    end
`endif

    // Registered nav pulses, one cycle wide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) nav_pulse <= '0;
        else        nav_pulse <= pulse_next;
    end

endmodule

// File: tb/tb_pad_input_conditioner.sv
// Self-checking bench for pad_input_conditioner with a small SAMPLE_DIV.
// Reference model tracks sample history, stick thresholds and time since the
// last nav change; works in both the edge-only and auto-repeat builds.
module tb_pad_input_conditioner;

    localparam int DIV   = 4;
    localparam int DEBN  = 3;
    localparam int DZ    = 40;
    localparam int HY    = 10;
    localparam int RDLY  = 4;
    localparam int RRATE = 2;

    logic        clk;
    logic        reset;
    logic [11:0] btn_raw;
    logic [7:0]  joy_x, joy_y;
    logic        sample_tick;
    logic [11:0] btn_state, btn_press, btn_release;
    logic [3:0]  stick_dir, nav_dir, nav_pulse;

    int checks;
    int failures;

    pad_input_conditioner #(
        .SAMPLE_DIV(DIV), .DEBOUNCE_N(DEBN), .DEADZONE(DZ), .HYST(HY),
        .REPEAT_DELAY(RDLY), .REPEAT_RATE(RRATE)
    ) dut (
        .clk(clk), .reset(reset), .btn_raw(btn_raw), .joy_x(joy_x), .joy_y(joy_y),
        .sample_tick(sample_tick), .btn_state(btn_state), .btn_press(btn_press),
        .btn_release(btn_release), .stick_dir(stick_dir), .nav_dir(nav_dir),
        .nav_pulse(nav_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          k;
    bit          hist [12][$];
    logic [11:0] m_state, m_press, m_release;
    logic        m_up, m_down, m_right, m_left;
    logic [3:0]  m_pulse;
    int          age;

    function automatic logic [3:0] m_stick();
        return {m_left, m_right, m_down, m_up};
    endfunction

    function automatic logic [3:0] m_nav();
        return m_stick() | m_state[11:8];
    endfunction

    task automatic model_reset();
        k = 0;
        m_state = '0; m_press = '0; m_release = '0; m_pulse = '0;
        m_up = 0; m_down = 0; m_right = 0; m_left = 0;
        age = 0;
        for (int b = 0; b < 12; b++) hist[b].delete();
    endtask

    task automatic model_edge();
        logic [11:0] ns;
        logic [3:0]  old_nav, new_nav;
        int          dx, dy;
        bit          all_diff;
        if ((k % DIV) == DIV - 1) begin
            old_nav = m_nav();
            ns = m_state;
            for (int b = 0; b < 12; b++) begin
                hist[b].push_back(btn_raw[b]);
                if (hist[b].size() > DEBN) void'(hist[b].pop_front());
                all_diff = (hist[b].size() == DEBN);
                foreach (hist[b][i]) if (hist[b][i] == m_state[b]) all_diff = 0;
                if (all_diff) ns[b] = ~m_state[b];
            end
            m_press   = ns & ~m_state;
            m_release = ~ns & m_state;
            m_state   = ns;
            dx = int'(joy_x) - 128;
            dy = int'(joy_y) - 128;
            if (dx >= DZ) m_right = 1; else if (dx < DZ - HY) m_right = 0;
            if (dx <= -DZ) m_left = 1; else if (dx > -(DZ - HY)) m_left = 0;
            if (dy >= DZ) m_up = 1; else if (dy < DZ - HY) m_up = 0;
            if (dy <= -DZ) m_down = 1; else if (dy > -(DZ - HY)) m_down = 0;
            new_nav = m_nav();
`ifdef PAD_AUTOREPEAT_EN
            if (new_nav == 0) begin
                m_pulse = 0; age = 0;
            end else if (new_nav != old_nav) begin
                m_pulse = new_nav & ~old_nav; age = 0;
            end else begin
                age++;
                m_pulse = (age >= RDLY && ((age - RDLY) % RRATE) == 0) ? new_nav : 4'd0;
            end
`else
            m_pulse = new_nav & ~old_nav;
`endif
        end else begin
            m_press = '0; m_release = '0; m_pulse = '0;
        end
        k++;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("sample_tick", {11'd0, sample_tick}, {11'd0, ((k % DIV) == DIV - 1)});
        chk("btn_state",   btn_state,   m_state);
        chk("btn_press",   btn_press,   m_press);
        chk("btn_release", btn_release, m_release);
        chk("stick_dir",   {8'd0, stick_dir}, {8'd0, m_stick()});
        chk("nav_dir",     {8'd0, nav_dir},   {8'd0, m_nav()});
        chk("nav_pulse",   {8'd0, nav_pulse}, {8'd0, m_pulse});
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_tick"},  {11'd0, sample_tick}, 12'd0);
        chk({tag, "_state"}, btn_state, 12'd0);
        chk({tag, "_press"}, btn_press, 12'd0);
        chk({tag, "_rel"},   btn_release, 12'd0);
        chk({tag, "_stick"}, {8'd0, stick_dir}, 12'd0);
        chk({tag, "_nav"},   {8'd0, nav_dir}, 12'd0);
        chk({tag, "_pulse"}, {8'd0, nav_pulse}, 12'd0);
    endtask

    // One clock: model the edge, then compare 1 time unit later.
    task automatic step();
        @(posedge clk);
        if (!reset) model_reset();
        else        model_edge();
        #1;
        check_all();
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n * DIV; i++) step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int vals [13];
        checks   = 0;
        failures = 0;
        vals = '{128, 168, 167, 160, 158, 157, 88, 89, 96, 98, 99, 0, 255};
        reset   = 1'b0;
        btn_raw = '0;
        joy_x   = 8'd128;
        joy_y   = 8'd128;
        model_reset();
        #12;
        check_zero("reset");
        step();
        reset = 1'b1;

        // Divider: ticks on the 4th, 8th, 12th cycle after release.
        for (int i = 0; i < 12; i++) step();

        // A held then released.
        btn_raw[0] = 1'b1;
        run_ticks(5);
        chk("a_held", {11'd0, btn_state[0]}, 12'd1);
        btn_raw[0] = 1'b0;
        run_ticks(5);
        chk("a_rel", {11'd0, btn_state[0]}, 12'd0);

        // B toggling every tick never settles.
        for (int i = 0; i < 20; i++) begin
            btn_raw[1] = ~btn_raw[1];
            run_ticks(1);
            chk("b_toggle", {11'd0, btn_state[1]}, 12'd0);
        end
        btn_raw[1] = 1'b0;
        run_ticks(4);

        // Stick thresholds and hysteresis on X.
        joy_x = 8'd168; run_ticks(1);
        chk("x168", {8'd0, stick_dir}, 12'h004);
        joy_x = 8'd160; run_ticks(1);
        chk("x160", {8'd0, stick_dir}, 12'h004);
        joy_x = 8'd157; run_ticks(1);
        chk("x157", {8'd0, stick_dir}, 12'h000);
        joy_x = 8'd88;  run_ticks(1);
        chk("x88",  {8'd0, stick_dir}, 12'h008);
        joy_x = 8'd128; joy_y = 8'd200; run_ticks(1);
        chk("y200", {8'd0, stick_dir}, 12'h001);
        joy_y = 8'd128; run_ticks(2);

        // D_UP held with auto-repeat; stick right added at t0+5.
        btn_raw[8] = 1'b1;
        run_ticks(3);
        run_ticks(4);
        joy_x = 8'd200;
        run_ticks(1);
        run_ticks(8);
        joy_x = 8'd128;
        run_ticks(3);
        btn_raw[8] = 1'b0;
        run_ticks(5);

        // Randomized buttons and stick near the thresholds.
        for (int i = 0; i < 150; i++) begin
            btn_raw = 12'($urandom);
            joy_x = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(vals[$urandom_range(0, 12)]);
            joy_y = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(vals[$urandom_range(0, 12)]);
            run_ticks($urandom_range(1, 6));
        end

        // Reset in the middle of auto-repeat.
        btn_raw = '0; joy_x = 8'd128; joy_y = 8'd128;
        run_ticks(4);
        btn_raw[9] = 1'b1;
        run_ticks(9);
        #3;
        reset = 1'b0;
        #1;
        check_zero("midreset");
        model_reset();
        step();
        step();
        reset = 1'b1;
        run_ticks(8);
        btn_raw = '0;
        run_ticks(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
